// File: rtl/keccak_parse_sampler.sv
// Rejection sampler on the keccak output FIFO: slices 64-bit squeeze words into 12-bit candidates
// and streams those below Q as coefficients. Define KECCAK_PARSE_DRAIN_EN to flush the FIFO after each polynomial.
module keccak_parse_sampler #(
    parameter int Q           = 3329,
    parameter int N_COEF      = 256,
    parameter int DW          = 64,
    parameter int CW          = 12,
    parameter int DRAIN_QUIET = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] kin_data,
    input  logic          kin_empty,
    output logic          gimme,
    output logic [CW-1:0] coef,
    output logic [7:0]    coef_idx,
    output logic          coef_valid,
    input  logic          coef_ready,
    output logic          busy,
    output logic          done
);
    localparam int BW = DW + CW;
    localparam int NW = $clog2(BW);
    localparam int AW = $clog2(N_COEF + 1);
    localparam logic [NW-1:0] CW_N = NW'(CW);
    localparam logic [NW-1:0] DW_N = NW'(DW);
    localparam logic [CW-1:0] Q_C  = CW'(Q);
    localparam logic [AW-1:0] NC   = AW'(N_COEF);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
`ifdef KECCAK_PARSE_DRAIN_EN
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam int QW = $clog2(DRAIN_QUIET + 1);
    logic [QW-1:0] quiet;
`endif

    logic [1:0]    state;
    logic [BW-1:0] bbuf;
    logic [NW-1:0] cnt;
    logic [AW-1:0] acc;
    logic          rd_pending;

    logic run, handshake, last, slot_free, extract, accept, grant;
    logic [CW-1:0] cand;

    assign run       = (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign handshake = coef_valid & coef_ready;
    assign last      = run & handshake & (acc == NC);
    assign slot_free = ~coef_valid | coef_ready;
    assign cand      = bbuf[CW-1:0];
    assign extract   = run & (cnt >= CW_N) & slot_free & (acc < NC);
    assign accept    = extract & (cand < Q_C);
`ifdef KECCAK_PARSE_DRAIN_EN
    // Draining only pops what is already there; it never asks the core to squeeze.
    assign gimme = (run & (cnt < CW_N) & ~rd_pending) | ((state == ST_DRAIN) & ~kin_empty);
`else
    assign gimme = run & (cnt < CW_N) & ~rd_pending;
`endif
    assign grant = gimme & ~kin_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            bbuf       <= '0;
            cnt        <= '0;
            acc        <= '0;
            rd_pending <= 1'b0;
            coef       <= '0;
            coef_idx   <= '0;
            coef_valid <= 1'b0;
            done       <= 1'b0;
`ifdef KECCAK_PARSE_DRAIN_EN
            quiet      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        acc        <= '0;
                        bbuf       <= '0;
                        cnt        <= '0;
                        rd_pending <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        // Residual bits and any read still in flight belong to no polynomial.
                        bbuf       <= '0;
                        cnt        <= '0;
                        rd_pending <= 1'b0;
                        coef_valid <= 1'b0;
`ifdef KECCAK_PARSE_DRAIN_EN
                        state      <= ST_DRAIN;
                        quiet      <= '0;
`else
                        state      <= ST_IDLE;
                        done       <= 1'b1;
`endif
                    end else begin
                        // Capture and extraction never coincide: reads only issue with cnt < CW.
                        if (rd_pending) begin
                            bbuf       <= bbuf | (BW'(kin_data) << cnt);
                            cnt        <= cnt + DW_N;
                            rd_pending <= 1'b0;
                        end else if (grant) begin
                            rd_pending <= 1'b1;
                        end
                        if (extract) begin
                            bbuf <= bbuf >> CW;
                            cnt  <= cnt - CW_N;
                        end
                        if (accept) begin
                            coef       <= cand;
                            coef_idx   <= acc[7:0];
                            coef_valid <= 1'b1;
                            acc        <= acc + 1'b1;
                        end else if (handshake) begin
                            coef_valid <= 1'b0;
                        end
                    end
                end
`ifdef KECCAK_PARSE_DRAIN_EN
                ST_DRAIN: begin
                    if (kin_empty) begin
                        if (quiet == QW'(DRAIN_QUIET - 1)) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                            quiet <= '0;
                        end else begin
                            quiet <= quiet + 1'b1;
                        end
                    end else begin
                        quiet <= '0;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keccak_parse_sampler.sv
// Scoreboard bench for keccak_parse_sampler: FIFO model feeds words, a monitor checks each coefficient handshake.
module tb_keccak_parse_sampler;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, kin_empty = 1'b1, coef_ready = 1'b1;
    logic [63:0] kin_data = '0;
    logic        gimme, coef_valid, busy, done;
    logic [11:0] coef;
    logic [7:0]  coef_idx;

    always #5 clk = ~clk;

    keccak_parse_sampler dut (
        .clk(clk), .rst(rst), .start(start), .kin_data(kin_data), .kin_empty(kin_empty),
        .gimme(gimme), .coef(coef), .coef_idx(coef_idx), .coef_valid(coef_valid),
        .coef_ready(coef_ready), .busy(busy), .done(done)
    );

    int tests = 0, fails = 0, done_cnt = 0;
    logic [63:0] fifo[$];
    bit          force_empty = 1'b0;
    logic [19:0] sb[$];

    logic [139:0] mbuf = '0;
    int           mcnt = 0, macc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference parse: LSB-first 12-bit slices of the concatenated word stream, keep < 3329.
    task automatic feed(input logic [63:0] w, input bit push_sb);
        logic [11:0] c;
        fifo.push_back(w);
        mbuf = mbuf | ({76'b0, w} << mcnt);
        mcnt += 64;
        while (mcnt >= 12 && macc < 256) begin
            c = mbuf[11:0];
            mbuf = mbuf >> 12;
            mcnt -= 12;
            if (c < 12'd3329) begin
                if (push_sb) sb.push_back({c, 8'(macc)});
                macc++;
            end
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin @(negedge clk); #3; end
    endtask

    task automatic wait_sb(input int lim, input string nm);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin @(negedge clk); #3; n++; end
        chk(nm, sb.size(), 0);
    endtask

    // FIFO model: kin_empty updated on negedge, grant decided once gimme has settled.
    always @(negedge clk) begin
        kin_empty = force_empty || (fifo.size() == 0);
        #1;
        if (rst && gimme && !kin_empty) kin_data = fifo.pop_front();
    end

    always @(negedge clk) begin
        logic [19:0] e;
        #2;
        if (rst && done) done_cnt++;
        if (rst && coef_valid && coef_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_coef: got coef %0d idx %0d expected none", coef, coef_idx);
            end else begin
                e = sb.pop_front();
                if ({coef, coef_idx} !== e) begin
                    fails++;
                    $display("FAIL coef_stream: got coef %0d idx %0d expected coef %0d idx %0d",
                             coef, coef_idx, e[19:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        logic [11:0] c0;
        logic [7:0]  i0;
        int          n;
        // reset state
        cyc(3);
        chk("rst_gimme", gimme, 0);
        chk("rst_coef", coef, 0);
        chk("rst_idx", coef_idx, 0);
        chk("rst_valid", coef_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk); rst = 1'b1;

        // mid-run async reset
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc(2);
        chk("t1_busy_run", busy, 1);
        chk("t1_gimme_run", gimme, 1);
        rst = 1'b0; #1;
        chk("t1_busy_rst", busy, 0);
        chk("t1_gimme_rst", gimme, 0);
        chk("t1_valid_rst", coef_valid, 0);
        cyc(2);
        @(negedge clk); rst = 1'b1;
        cyc(3);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_gimme", gimme, 0);

        // one word: 0, 3329 (dropped), 3328, 0, 0
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        mbuf = '0; mcnt = 0; macc = 0;
        sb.push_back({12'd0, 8'd0});
        sb.push_back({12'd3328, 8'd1});
        sb.push_back({12'd0, 8'd2});
        sb.push_back({12'd0, 8'd3});
        feed(64'h0000_000D_00D0_1000, 1'b0);
        wait_sb(40, "t2_drain");
        cyc(3);
        chk("t2_gimme_again", gimme, 1);

        // all-ones words: every candidate rejected
        feed(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        feed(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        cyc(40);
        chk("t4_fifo_consumed", fifo.size(), 0);
        chk("t4_gimme", gimme, 1);
        chk("t4_valid", coef_valid, 0);

        // empty FIFO held while asking, then a word arrives with the sink stalled
        coef_ready = 1'b0;
        force_empty = 1'b1;
        for (int k = 1; k <= 5; k++) sb.push_back({12'(k), 8'(k + 3)});
        feed(64'h0005_0040_0300_2001, 1'b0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (gimme !== 1'b1 || coef_valid !== 1'b0) n++;
        end
        chk("t5_held_gimme_cycles_bad", n, 0);
        chk("t5_fifo_untouched", fifo.size(), 1);
        force_empty = 1'b0;
        n = 0;
        while (!coef_valid && n < 20) begin cyc(1); n++; end
        chk("t3_first_valid", coef_valid, 1);
        chk("t3_first_coef", coef, 1);
        chk("t3_first_idx", coef_idx, 4);
        c0 = coef; i0 = coef_idx;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (coef !== c0 || coef_idx !== i0 || coef_valid !== 1'b1) n++;
        end
        chk("t3_stall_unstable_cycles", n, 0);
        @(negedge clk); coef_ready = 1'b1;
        wait_sb(40, "t3_resume");
        chk("t3_no_done_yet", done_cnt, 0);

        // rest of the polynomial from a pseudo-random stream
        while (macc < 256) feed({$urandom(), $urandom()}, 1'b1);
`ifdef KECCAK_PARSE_DRAIN_EN
        for (int k = 0; k < 3; k++) fifo.push_back({$urandom(), $urandom()});
`endif
        wait_sb(3000, "t6_all_coefs");
        n = 0;
        while (done_cnt == 0 && n < 50) begin cyc(1); n++; end
        cyc(5);
        chk("t6_done_pulses", done_cnt, 1);
        chk("t6_busy", busy, 0);
        chk("t6_gimme", gimme, 0);
        chk("t6_valid", coef_valid, 0);
        chk("t6_fifo_left", fifo.size(), 0);
        chk("t6_model_acc", macc, 256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
